// File: rtl/data_memory_responder.sv
// Data-memory slave for the core: word-addressed RAM plus an I/O page with a cycle
// counter, a host-bound transmit FIFO and a control/status register.
module data_memory_responder #(
   parameter int unsigned RAM_WORDS = 1024,
   parameter int unsigned TX_DEPTH  = 8,
   parameter logic [31:0] IO_BASE   = 32'h0001_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_memory_addr,
   input  logic [31:0] data_memory_wd,
   input  logic        data_memory_we,
   output logic [31:0] data_memory_data,
   output logic [31:0] tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        done,
   output logic        bus_error,
   output logic        tx_overflow
);

   localparam int RAM_AW = $clog2(RAM_WORDS);
   localparam int TX_AW  = $clog2(TX_DEPTH);
   localparam int TX_CW  = TX_AW + 1;
   localparam logic [29:0] IO_WORD = IO_BASE[31:2];

   localparam int IO_CYCLE  = 0;
   localparam int IO_TXDATA = 1;
   localparam int IO_STATUS = 2;
   localparam int IO_CTRL   = 3;

   logic [29:0]       word_idx;
   logic              ram_hit;
   logic [3:0]        io_hit;
   logic              unmapped;
   logic              unused_addr_bits;

   logic [31:0]       ram_mem [RAM_WORDS];
   logic [RAM_AW-1:0] ram_addr;

   logic [31:0]       cycle_reg;

   logic [31:0]       tx_mem [TX_DEPTH];
   logic [TX_AW-1:0]  rd_ptr_reg;
   logic [TX_AW-1:0]  wr_ptr_reg;
   logic [TX_CW-1:0]  count_reg;
   logic [TX_CW-1:0]  count_next;
   logic              tx_full;
   logic              tx_empty;
   logic              push_req;
   logic              push_ok;
   logic              pop;
   logic              overflow_evt;

   logic              ctrl_we;
   logic              flag_clear;
   logic              bus_error_evt;
   logic              done_reg;
   logic              bus_error_reg;
   logic              tx_overflow_reg;
   logic [31:0]       status_word;

   // ---------------------------------------------------------------- decode
   assign word_idx         = data_memory_addr[31:2];
   assign unused_addr_bits = ^data_memory_addr[1:0];
   assign ram_hit          = (word_idx < 30'(RAM_WORDS));
   assign ram_addr         = word_idx[RAM_AW-1:0];

   // RAM takes precedence should the I/O page ever be placed inside it.
   for (genvar gi = 0; gi < 4; gi++) begin : g_io_decode
      assign io_hit[gi] = !ram_hit && (word_idx == IO_WORD + 30'(gi));
   end

   assign unmapped = !ram_hit && (io_hit == 4'b0000);

   // ---------------------------------------------------------------- RAM
   always_ff @(posedge clk) begin
      if (reset && data_memory_we && ram_hit) begin
         ram_mem[ram_addr] <= data_memory_wd;
      end
   end

   // ---------------------------------------------------------------- cycle counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         cycle_reg <= 32'd0;
      end else begin
         cycle_reg <= cycle_reg + 32'd1;
      end
   end

   // ---------------------------------------------------------------- transmit FIFO
   assign tx_full      = (count_reg == TX_CW'(TX_DEPTH));
   assign tx_empty     = (count_reg == '0);
   assign tx_valid     = !tx_empty;
   assign tx_data      = tx_mem[rd_ptr_reg];
   assign pop          = tx_valid && tx_ready;
   assign push_req     = data_memory_we && io_hit[IO_TXDATA];
   assign push_ok      = push_req && (!tx_full || pop);
   assign overflow_evt = push_req && tx_full && !pop;

   always_comb begin
      count_next = count_reg;
      case ({push_ok, pop})
         2'b10:   count_next = count_reg + TX_CW'(1);
         2'b01:   count_next = count_reg - TX_CW'(1);
         default: count_next = count_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset && push_ok) begin
         tx_mem[wr_ptr_reg] <= data_memory_wd;
      end
   end

   // Pointers wrap naturally because TX_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + TX_AW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + TX_AW'(1);
         end
         count_reg <= count_next;
      end
   end

   // ---------------------------------------------------------------- control / status flags
   assign ctrl_we       = data_memory_we && io_hit[IO_CTRL];
   assign flag_clear    = ctrl_we && data_memory_wd[1];
   assign bus_error_evt = data_memory_we &&
                          (io_hit[IO_CYCLE] || io_hit[IO_STATUS] || unmapped);

   // A new error event in the same cycle as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (!reset) begin
         done_reg        <= 1'b0;
         bus_error_reg   <= 1'b0;
         tx_overflow_reg <= 1'b0;
      end else begin
         done_reg        <= done_reg | (ctrl_we && data_memory_wd[0]);
         bus_error_reg   <= bus_error_evt | (bus_error_reg & !flag_clear);
         tx_overflow_reg <= overflow_evt | (tx_overflow_reg & !flag_clear);
      end
   end

   assign done        = done_reg;
   assign bus_error   = bus_error_reg;
   assign tx_overflow = tx_overflow_reg;

   // ---------------------------------------------------------------- read mux
   assign status_word = {16'b0, 8'(count_reg), 6'b0, tx_full, tx_empty};

   always_comb begin
      data_memory_data = 32'd0;
      if (ram_hit) begin
         data_memory_data = ram_mem[ram_addr];
      end else if (io_hit[IO_CYCLE]) begin
         data_memory_data = cycle_reg;
      end else if (io_hit[IO_STATUS]) begin
         data_memory_data = status_word;
      end else if (io_hit[IO_CTRL]) begin
         data_memory_data = {29'b0, bus_error_reg, tx_overflow_reg, done_reg};
      end
   end

endmodule

// File: doc/data_memory_responder.md
Name: data_memory_responder

Overview:
- Slave end of the core's data-memory port. It answers core_top's data_memory_addr/wd/we with data_memory_data.
- Contains a word-addressed RAM and a small memory-mapped I/O page: free-running cycle counter, a transmit FIFO toward the host, and a control/status register.
- Read path is combinational, because the core's memory stage captures read data at the same edge it presents the address. Writes are synchronous.

Parameters:
- RAM_WORDS, 1024, RAM depth in 32-bit words; power of two.
- TX_DEPTH, 8, transmit FIFO depth in words; power of two, at least 2.
- IO_BASE, 32'h0001_0000, byte base address of the I/O page.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- data_memory_addr  in  32  byte address from core; bits [1:0] ignored.
- data_memory_wd  in  32  write data from core.
- data_memory_we  in  1  write enable from core.
- data_memory_data  out  32  combinational read data to core.
- tx_data  out  32  FIFO head word toward host.
- tx_valid  out  1  FIFO non-empty.
- tx_ready  in  1  host accepts head word when tx_valid is high.
- done  out  1  sticky program-done flag.
- bus_error  out  1  sticky: write to an unmapped or read-only address.
- tx_overflow  out  1  sticky: push attempted while the FIFO was full with no pop.

Behaviour:
- Address decode uses word index = addr[31:2].
  - RAM: byte addr < RAM_WORDS*4.
  - IO_BASE+0x0 CYCLE (RO).
  - IO_BASE+0x4 TX_DATA (WO).
  - IO_BASE+0x8 TX_STATUS (RO).
  - IO_BASE+0xC CTRL (R/W).
  - Everything else is unmapped.
- Reads are purely combinational and have no side effects; there is no read strobe.
  - RAM returns the array word.
  - CYCLE returns the counter.
  - TX_DATA reads 0.
  - TX_STATUS returns {16'b0, count[7:0], 6'b0, full, empty}.
  - CTRL returns {29'b0, bus_error, tx_overflow, done}.
  - Unmapped addresses read 0.
- RAM write (we=1, in range): array updated at the edge. A same-cycle read of that address returns the old word. RAM contents are not reset; initial contents are undefined unless preloaded.
- CYCLE: 0 after reset, +1 every cycle, wraps 32'hFFFF_FFFF -> 0. Writes to it are ignored and set bus_error.
- TX_DATA write pushes wd into the FIFO.
  - Full and no pop in the same cycle: word dropped, tx_overflow set.
  - Full with a pop in the same cycle: push accepted, count unchanged.
  - Empty with a push: no bypass. tx_valid rises the cycle after the push.
- Pop happens when tx_valid && tx_ready at the edge. tx_data always shows the head (FIFO order); it is don't-care when empty.
- Count ranges 0..TX_DEPTH. Pointers wrap modulo TX_DEPTH. empty = (count==0), full = (count==TX_DEPTH).
- TX_STATUS write: ignored, sets bus_error.
- CTRL write:
  - wd[0]=1 sets done.
  - wd[1]=1 clears tx_overflow and bus_error.
  - If a clear and a new error event coincide, the set wins.
  - done clears only on reset.
- Unmapped write: ignored, sets bus_error.
- Reset (reset=0 at edge): counter=0, FIFO pointers/count=0 (tx_valid=0), done=0, bus_error=0, tx_overflow=0. data_memory_data follows the decode (CYCLE reads 0). Reset asserted mid-stream discards FIFO contents; a concurrent core write is ignored. RAM is not altered.
- Latency summary: read 0 cycles; write 1 edge; FIFO push to tx_valid 1 cycle.

Test Plan:
- Write 32'hDEAD_BEEF to 0x0000_0010, read same addr next cycle -> data_memory_data=32'hDEAD_BEEF; in the write cycle itself it shows the prior value.
- Reset, then read IO_BASE+0x0 at cycles 0,1,5 after release -> 0,1,5. Force counter to 32'hFFFF_FFFF -> next read 0.
- tx_ready=0, push 9 words (1..9) to IO_BASE+0x4 with TX_DEPTH=8.
  - -> TX_STATUS count=8, full=1; tx_overflow=1.
  - Then tx_ready=1 -> tx_data sequence 1..8, then tx_valid=0, empty=1.
- FIFO full, push 0xAA while popping -> count stays 8, tx_overflow stays 0, 0xAA emerges last.
- Write to 0x0002_0000 -> bus_error=1, read 0. Write CTRL=0x2 -> bus_error=0. Write CTRL=0x1 -> done=1, CTRL reads 0x1.
- Assert reset with 3 words queued and done=1 -> next cycle tx_valid=0, count=0, done=0, all flags 0; previously written RAM word still reads back.
